bcd_count2_scan: RTL and testbench

//   Two-digit BCD up/down counter (00..99) with a display-scan select generator.

---
 rtl/bcd_count2_scan.sv | 107 ++++++++++
 tb/tb_bcd_count2_scan.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/bcd_count2_scan.sv
// Two-digit BCD up/down counter (00..99) with carry and a free-running display scan select.
// Define BCD_SATURATE_EN to hold at 99/00 instead of wrapping; Carry is then tied to 0.
module bcd_count2_scan #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       Up,
  input  logic       Load,
  input  logic [3:0] LoadOnes,
  input  logic [3:0] LoadTens,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic       ScanSel,
  output logic       Carry
);

  localparam int unsigned   DW       = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] div_q, div_d;
  logic          sel_q, sel_d;
  logic          div_wrap;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (Load) begin
      ones_d = clamp9(LoadOnes);
      tens_d = clamp9(LoadTens);
    end else if (En) begin
      if (Up) begin
        if (ones_q < 4'd9) begin
          ones_d = ones_q + 4'd1;
        end else if (tens_q < 4'd9) begin
          ones_d = '0;
          tens_d = tens_q + 4'd1;
        end else begin
`ifdef BCD_SATURATE_EN
          ones_d = ones_q;
`else
          ones_d  = '0;
          tens_d  = '0;
          carry_d = 1'b1;
`endif
        end
      end else begin
        if (ones_q != 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
`ifdef BCD_SATURATE_EN
          ones_d = ones_q;
`else
          ones_d  = 4'd9;
          tens_d  = 4'd9;
          carry_d = 1'b1;
`endif
        end
      end
    end
  end

  // Scan divider runs regardless of En/Load/Up; only reset restarts the phase.
  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    sel_d    = sel_q ^ div_wrap;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ones_q  <= '0;
      tens_q  <= '0;
      carry_q <= 1'b0;
      div_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      carry_q <= carry_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
    end
  end

  assign Ones    = ones_q;
  assign Tens    = tens_q;
  assign ScanSel = sel_q;
`ifdef BCD_SATURATE_EN
  assign Carry   = 1'b0;
`else
  assign Carry   = carry_q;
`endif

endmodule

// File: tb/tb_bcd_count2_scan.sv
// Scoreboard bench for bcd_count2_scan: integer-count reference model, two scan divisors (3 and 1).
module tb_bcd_count2_scan;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       En = 1'b0;
  logic       Up = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] LoadOnes = '0;
  logic [3:0] LoadTens = '0;

  logic [3:0] ones3, tens3, ones1, tens1;
  logic       sel3, carry3, sel1, carry1;

  always #5 Clk = ~Clk;

  bcd_count2_scan #(.SCAN_DIV(3)) u_div3 (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load),
    .LoadOnes(LoadOnes), .LoadTens(LoadTens),
    .Ones(ones3), .Tens(tens3), .ScanSel(sel3), .Carry(carry3)
  );

  bcd_count2_scan #(.SCAN_DIV(1)) u_div1 (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load),
    .LoadOnes(LoadOnes), .LoadTens(LoadTens),
    .Ones(ones1), .Tens(tens1), .ScanSel(sel1), .Carry(carry1)
  );

  typedef struct {
    int ones;
    int tens;
    int carry;
    int sel3;
    int sel1;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference: the count is a plain integer 0..99; scan select is derived from edges since reset.
  int   cnt = 0;
  int   cy  = 0;
  int   k   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit ld, input int lo, input int lt,
                       input bit en, input bit up);
    exp_t e;
    @(negedge Clk);
    Rst      = rst;
    Load     = ld;
    LoadOnes = 4'(lo);
    LoadTens = 4'(lt);
    En       = en;
    Up       = up;
    if (rst) begin
      cnt = 0; cy = 0; k = 0;
    end else begin
      k++;
      cy = 0;
      if (ld) begin
        cnt = (lt > 9 ? 9 : lt) * 10 + (lo > 9 ? 9 : lo);
      end else if (en && up) begin
        if (cnt == 99) begin
`ifndef BCD_SATURATE_EN
          cnt = 0; cy = 1;
`endif
        end else cnt = cnt + 1;
      end else if (en) begin
        if (cnt == 0) begin
`ifndef BCD_SATURATE_EN
          cnt = 99; cy = 1;
`endif
        end else cnt = cnt - 1;
      end
    end
    e.ones  = cnt % 10;
    e.tens  = cnt / 10;
    e.carry = cy;
    e.sel3  = (k / 3) % 2;
    e.sel1  = k % 2;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a new state every cycle; compare 2 time units after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        check("ones3",  int'(ones3),  e.ones);
        check("tens3",  int'(tens3),  e.tens);
        check("carry3", int'(carry3), e.carry);
        check("sel3",   int'(sel3),   e.sel3);
        check("ones1",  int'(ones1),  e.ones);
        check("tens1",  int'(tens1),  e.tens);
        check("carry1", int'(carry1), e.carry);
        check("sel1",   int'(sel1),   e.sel1);
      end
    end
  end

  initial begin
    int lo, lt;
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    repeat (10) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 9, 4, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 1, 1);
    drive(0, 1, 9, 9, 0, 0);
    drive(0, 0, 0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 12, 15, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 3, 7, 1, 1);
    drive(0, 1, 9, 9, 1, 1);
    drive(0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (16) drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1);
    repeat (8) drive(0, 0, 0, 0, 1, 1);

    // Random walk: mostly stepping, occasional loads (incl. out-of-range digits) and rare resets.
    for (int i = 0; i < 500; i++) begin
      lo = $urandom_range(15);
      lt = $urandom_range(15);
      drive($urandom_range(199) == 0, $urandom_range(15) == 0, lo, lt,
            $urandom_range(3) != 0, $urandom_range(1) == 1);
    end
    drive(0, 0, 0, 0, 0, 0);

    @(posedge Clk);
    #5;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
